// File: rtl/mult4u_chk_pkg.sv
// Shared types and constants for the 4-bit unsigned multiplier result checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mult4u_chk_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;
   localparam int STEPS  = 4;
   localparam int STEP_W = $clog2(STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // One shift-add partial product, zero-extended to the product width.
   function automatic logic [PROD_W-1:0] partial(input logic [OP_W-1:0]   op_a,
                                                 input logic              bit_b,
                                                 input logic [STEP_W-1:0] shamt);
      partial = bit_b ? (PROD_W'(op_a) << shamt) : '0;
   endfunction

endpackage

// File: rtl/mult4u_sat_cnt.sv
// Saturating up-counter: sticks at all-ones, clear takes effect before increment.
// Latency: count updates on the edge where inc/clr are sampled.
// Backpressure: none; inc and clr are single-cycle strobes.
module mult4u_sat_cnt #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = '1;
   localparam logic [W-1:0] CNT_ONE = W'(1);

   // Clear-then-increment: a coincident clr and inc leaves the counter at one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= inc ? CNT_ONE : '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule

// File: rtl/mult4u_result_checker.sv
// Recomputes a*b with a 4-step shift-add engine and flags products that disagree.
// Latency: result registered 4 edges after accept; 6 cycles minimum per triple.
// Backpressure: holds the result in DONE until out_ready; in_ready low until then.
// Optional MULT4U_CHK_STICKY_EN adds err_sticky, set on mismatch, cleared by clr_cnt.
module mult4u_result_checker
   import mult4u_chk_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OP_W-1:0]   a,
   input  logic [OP_W-1:0]   b,
   input  logic [PROD_W-1:0] prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_err,
   output logic [PROD_W-1:0] golden,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  err_count
`ifdef MULT4U_CHK_STICKY_EN
   ,
   output logic              err_sticky
`endif
);

   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

   state_t              state;
   logic [OP_W-1:0]     a_r;
   logic [OP_W-1:0]     b_r;
   logic [PROD_W-1:0]   prod_r;
   logic [PROD_W-1:0]   acc;
   logic [STEP_W-1:0]   step;

   logic [PROD_W-1:0]   acc_nxt;
   logic                last_step;
   logic                mismatch;

   // Next accumulator value and the end-of-calculation compare.
   always_comb begin
      acc_nxt   = acc + partial(a_r, b_r[step], step);
      last_step = (state == CALC) && (step == LAST_STEP);
      mismatch  = last_step && (acc_nxt != prod_r);
   end

   // Control FSM and shift-add datapath; every output is a register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_err   <= 1'b0;
         golden    <= '0;
         a_r       <= '0;
         b_r       <= '0;
         prod_r    <= '0;
         acc       <= '0;
         step      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_ready && in_valid) begin
                  a_r      <= a;
                  b_r      <= b;
                  prod_r   <= prod;
                  acc      <= '0;
                  step     <= '0;
                  in_ready <= 1'b0;
                  state    <= CALC;
               end else begin
                  // First cycle after reset release raises in_ready here.
                  in_ready <= 1'b1;
               end
            end
            CALC: begin
               acc  <= acc_nxt;
               step <= step + STEP_W'(1);
               if (last_step) begin
                  golden    <= acc_nxt;
                  out_err   <= mismatch;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               // out_err and golden keep their last values after hand-off.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   mult4u_sat_cnt #(
      .W(CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (mismatch),
      .clr   (clr_cnt),
      .cnt   (err_count)
   );

`ifdef MULT4U_CHK_STICKY_EN
   // Sticky fault flag; a mismatch coinciding with clr_cnt wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sticky <= 1'b0;
      end else if (clr_cnt) begin
         err_sticky <= mismatch;
      end else if (mismatch) begin
         err_sticky <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mult4u_result_checker.sv
// Directed-vector bench for mult4u_result_checker with hand-computed expectations.
// Latency: checks the 4-edge accept-to-result timing and 2-edge re-accept.
// Backpressure: exercises out_ready held low with a pending upstream triple.
module tb_mult4u_result_checker;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       a;
   logic [3:0]       b;
   logic [7:0]       prod;
   logic             out_valid;
   logic             out_ready;
   logic             out_err;
   logic [7:0]       golden;
   logic             clr_cnt;
   logic [CNT_W-1:0] err_count;
`ifdef MULT4U_CHK_STICKY_EN
   logic             err_sticky;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   logic exp_sticky = 1'b0;

   mult4u_result_checker #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .prod      (prod),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_err   (out_err),
      .golden    (golden),
      .clr_cnt   (clr_cnt),
      .err_count (err_count)
`ifdef MULT4U_CHK_STICKY_EN
      ,
      .err_sticky(err_sticky)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic check_sticky(input string tag);
`ifdef MULT4U_CHK_STICKY_EN
      check(tag, 32'(err_sticky), 32'(exp_sticky));
`endif
   endtask

   // Wait (bounded) for in_ready, present a triple, return at the negedge after accept.
   task automatic send(input logic [3:0] ta, input logic [3:0] tb_v, input logic [7:0] tp);
      int w = 0;
      @(negedge clk);
      while (!in_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) check("send_timeout", 32'(in_ready), 32'd1);
      a = ta; b = tb_v; prod = tp; in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count edges from accept until out_valid is seen, bounded.
   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   // Full transaction with out_ready=1: latency, result fields, count, release.
   task automatic run(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                      input logic [7:0] tp, input logic [7:0] exp_g, input logic exp_e,
                      input logic [CNT_W-1:0] exp_cnt);
      int lat;
      out_ready = 1'b1;
      send(ta, tb_v, tp);
      wait_result(lat);
      if (exp_e) exp_sticky = 1'b1;
      check({tag, "_lat"},    32'(lat),       32'd4);
      check({tag, "_golden"}, 32'(golden),    32'(exp_g));
      check({tag, "_err"},    32'(out_err),   32'(exp_e));
      check({tag, "_cnt"},    32'(err_count), 32'(exp_cnt));
      check_sticky({tag, "_sticky"});
      @(posedge clk);
      @(negedge clk);
      check({tag, "_release"}, 32'(out_valid), 32'd0);
   endtask

   typedef struct {
      logic [3:0] ta;
      logic [3:0] tb;
      logic [7:0] tp;
      logic [7:0] g;
      logic       e;
      logic [7:0] c;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int lat;
      vecs[0] = '{4'd9,  4'd0,  8'h00, 8'h00, 1'b0, 8'd2};
      vecs[1] = '{4'd15, 4'd1,  8'h0F, 8'h0F, 1'b0, 8'd2};
      vecs[2] = '{4'd8,  4'd8,  8'h41, 8'h40, 1'b1, 8'd3};
      vecs[3] = '{4'd10, 4'd12, 8'h78, 8'h78, 1'b0, 8'd3};
      vecs[4] = '{4'd6,  4'd11, 8'h43, 8'h42, 1'b1, 8'd4};

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_cnt = 1'b0;
      a = '0; b = '0; prod = '0;
      repeat (3) @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_err",   32'(out_err),   32'd0);
      check("rst_golden",    32'(golden),    32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check_sticky("rst_sticky");
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      // Basic match and mismatch.
      run("t15x15", 4'd15, 4'd15, 8'hE1, 8'hE1, 1'b0, 8'd0);
      check("post_in_ready", 32'(in_ready), 32'd1);
      run("t3x5", 4'd3, 4'd5, 8'h00, 8'h0F, 1'b1, 8'd1);

      // Backpressure: result held, pending triple ignored until release.
      out_ready = 1'b0;
      send(4'd7, 4'd9, 8'h3F);
      wait_result(lat);
      check("bp_lat",    32'(lat),     32'd4);
      check("bp_golden", 32'(golden),  32'h3F);
      check("bp_err",    32'(out_err), 32'd0);
      a = 4'd1; b = 4'd1; prod = 8'hFF; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_gold",  32'(golden),    32'h3F);
         check("bp_hold_err",   32'(out_err),   32'd0);
         check("bp_hold_rdy",   32'(in_ready),  32'd0);
         check("bp_hold_cnt",   32'(err_count), 32'd1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_rel_valid", 32'(out_valid), 32'd0);
      check("bp_rel_rdy",   32'(in_ready),  32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_accept_rdy", 32'(in_ready), 32'd0);
      wait_result(lat);
      exp_sticky = 1'b1;
      check("bp2_lat",    32'(lat),       32'd4);
      check("bp2_golden", 32'(golden),    32'h01);
      check("bp2_err",    32'(out_err),   32'd1);
      check("bp2_cnt",    32'(err_count), 32'd2);
      @(posedge clk);
      @(negedge clk);

      // Directed table.
      foreach (vecs[i])
         run($sformatf("vec%0d", i), vecs[i].ta, vecs[i].tb, vecs[i].tp,
             vecs[i].g, vecs[i].e, vecs[i].c);

      // Bring the count to 7.
      run("pre5", 4'd1, 4'd2, 8'h00, 8'h02, 1'b1, 8'd5);
      run("pre6", 4'd1, 4'd2, 8'h00, 8'h02, 1'b1, 8'd6);
      run("pre7", 4'd1, 4'd2, 8'h00, 8'h02, 1'b1, 8'd7);

      // clr_cnt on the result edge of a mismatch.
      send(4'd1, 4'd2, 8'h00);
      repeat (3) @(posedge clk);
      @(negedge clk);
      clr_cnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_cnt = 1'b0;
      check("clr_hit_valid", 32'(out_valid), 32'd1);
      check("clr_hit_err",   32'(out_err),   32'd1);
      check("clr_hit_cnt",   32'(err_count), 32'd1);
      check_sticky("clr_hit_sticky");
      @(posedge clk);
      @(negedge clk);

      // Plain clear while idle.
      clr_cnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr_cnt = 1'b0;
      exp_sticky = 1'b0;
      check("clr_idle_cnt", 32'(err_count), 32'd0);
      check_sticky("clr_idle_sticky");

      // Saturation: 300 mismatching triples.
      for (int i = 0; i < 300; i++) begin
         send(4'd1, 4'd1, 8'h00);
         wait_result(lat);
         if (lat != 4) check("sat_lat", 32'(lat), 32'd4);
         @(posedge clk);
         @(negedge clk);
         if (i == 254) check("sat_reach", 32'(err_count), 32'd255);
      end
      exp_sticky = 1'b1;
      check("sat_final", 32'(err_count), 32'd255);
      check_sticky("sat_sticky");

      // Asynchronous reset during the second CALC cycle.
      send(4'd2, 4'd3, 8'h00);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      exp_sticky = 1'b0;
      check("arst_valid",   32'(out_valid), 32'd0);
      check("arst_cnt",     32'(err_count), 32'd0);
      check("arst_err",     32'(out_err),   32'd0);
      check("arst_golden",  32'(golden),    32'd0);
      check("arst_in_rdy",  32'(in_ready),  32'd0);
      check_sticky("arst_sticky");
      @(negedge clk);
      rst_n = 1'b1;
      run("after_rst", 4'd2, 4'd6, 8'h0C, 8'h0C, 1'b0, 8'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
